// File: rtl/ysyx_22041211_pipe_ctrl_pkg.sv
// Shared constants and types for the elastic stage chain and its users in the core top.
package ysyx_22041211_pipe_ctrl_pkg;

  // Default chain depth: IFU -> IDU -> EXU -> WB.
  localparam int PIPE_DEFAULT_STAGES = 4;

  // Occupancy counts the stages plus up to two skid entries, so it needs to reach STAGES+2.
  function automatic int occ_w(input int stages);
    return $clog2(stages + 3);
  endfunction

  // Redirect sources that the core top ORs into flush_i.
  typedef enum logic [1:0] {
    FLUSH_NONE   = 2'd0,
    FLUSH_BRANCH = 2'd1,
    FLUSH_JMP    = 2'd2,
    FLUSH_CSR    = 2'd3
  } flush_src_e;

endpackage

// File: rtl/ysyx_22041211_skid_buf.sv
// 2-entry input FIFO. Ready is taken from a flop so upstream never sees a combinational path
// from downstream backpressure. When empty and the consumer is ready, an entry passes straight
// through in the same cycle.
module ysyx_22041211_skid_buf #(
  parameter int DATA_LEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [DATA_LEN-1:0] in_data_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [DATA_LEN-1:0] out_data_o,
  output logic [1:0]          count_o
);

  logic [DATA_LEN-1:0] mem [2];
  logic                rd_ptr, wr_ptr, rdy_q;
  logic [1:0]          cnt, cnt_nxt;
  logic                push, pop, wr, rd;

  // Handshake decode; a flush suppresses acceptance in its own cycle.
  always_comb begin
    in_ready_o  = rdy_q & ~flush_i;
    push        = in_valid_i & in_ready_o;
    out_valid_o = (cnt != 2'd0) | push;
    out_data_o  = (cnt != 2'd0) ? mem[rd_ptr] : in_data_i;
    pop         = out_valid_o & out_ready_i;
    // Pass-through when empty: the entry is consumed without being written.
    wr          = push & ~(pop & (cnt == 2'd0));
    rd          = pop & (cnt != 2'd0);
    cnt_nxt     = cnt + {1'b0, wr} - {1'b0, rd};
  end

  // Count, pointers and the registered ready ("not full after this edge").
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      rdy_q  <= 1'b1;
    end else if (flush_i) begin
      cnt    <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      rdy_q  <= 1'b1;
    end else begin
      cnt    <= cnt_nxt;
      rd_ptr <= rd_ptr ^ rd;
      wr_ptr <= wr_ptr ^ wr;
      rdy_q  <= (cnt_nxt != 2'd2);
    end
  end

  // Payload storage, written only on a real enqueue; no reset needed.
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= in_data_i;
  end

  assign count_o = cnt;

endmodule

// File: rtl/ysyx_22041211_pipe_ctrl.sv
// Elastic valid/ready stage chain with optional input skid buffer, global flush and a
// retirement counter. Stage 0 is the youngest; stage STAGES-1 drives the output.
module ysyx_22041211_pipe_ctrl
  import ysyx_22041211_pipe_ctrl_pkg::*;
#(
  parameter int DATA_LEN = 32,
  parameter int STAGES   = PIPE_DEFAULT_STAGES,
  parameter int SKID     = 1,
  parameter int CNT_LEN  = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [DATA_LEN-1:0]          in_data_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [DATA_LEN-1:0]          out_data_o,
  input  logic                         flush_i,
  output logic [STAGES-1:0]            stage_valid_o,
  output logic [STAGES*DATA_LEN-1:0]   stage_data_o,
  output logic [occ_w(STAGES)-1:0]     occupancy_o,
  output logic [CNT_LEN-1:0]           retire_cnt_o
);

  localparam int OCC_W = occ_w(STAGES);

  logic [STAGES-1:0]                v, adv, chain_v;
  logic [STAGES-1:0][DATA_LEN-1:0]  d, chain_d;
  logic                             src_valid;
  logic [DATA_LEN-1:0]              src_data;
  logic [1:0]                       skid_cnt;

  generate
    if (SKID != 0) begin : g_skid
      ysyx_22041211_skid_buf #(.DATA_LEN(DATA_LEN)) u_skid (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .out_valid_o (src_valid),
        .out_ready_i (adv[0]),
        .out_data_o  (src_data),
        .count_o     (skid_cnt)
      );
    end else begin : g_noskid
      assign in_ready_o = adv[0] & ~flush_i;
      assign src_valid  = in_valid_i & in_ready_o;
      assign src_data   = in_data_i;
      assign skid_cnt   = 2'd0;
    end
  endgenerate

  // Advance chain from the output back: a stage moves if it is empty or its successor moves,
  // so bubbles collapse in the same cycle.
  always_comb begin
    adv = '0;
    adv[STAGES-1] = ~v[STAGES-1] | out_ready_i;
    for (int i = STAGES - 2; i >= 0; i--) adv[i] = ~v[i] | adv[i+1];
  end

  // What each stage would load: its predecessor, or the input side for stage 0.
  always_comb begin
    chain_v    = '0;
    chain_d    = '0;
    chain_v[0] = src_valid;
    chain_d[0] = src_data;
    for (int i = 1; i < STAGES; i++) begin
      chain_v[i] = v[i-1];
      chain_d[i] = d[i-1];
    end
  end

  // Stage valid bits; flush kills every in-flight entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v <= '0;
    end else if (flush_i) begin
      v <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++)
        if (adv[i]) v[i] <= chain_v[i];
    end
  end

  // Stage payloads, loaded only with a valid entry so a stalled output stays stable.
  always_ff @(posedge clk) begin
    for (int i = 0; i < STAGES; i++)
      if (adv[i] & chain_v[i]) d[i] <= chain_d[i];
  end

  // Retirement counter; an output handshake in a flush cycle still completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) retire_cnt_o <= '0;
    else if (out_valid_o & out_ready_i) retire_cnt_o <= retire_cnt_o + CNT_LEN'(1);
  end

  assign out_valid_o   = v[STAGES-1];
  assign out_data_o    = d[STAGES-1];
  assign stage_valid_o = v;
  assign stage_data_o  = d;
  assign occupancy_o   = OCC_W'($countones(v)) + OCC_W'(skid_cnt);

endmodule
